// File: rtl/pipe_stage_reg_pkg.sv
// pipe_stage_reg_pkg: shared stage payload types, bubble encodings and buffer state for pipeline registers
package pipe_stage_reg_pkg;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } stage_state_t;

    typedef enum logic [1:0] {
        RESULT_ALU,
        RESULT_MEM,
        RESULT_PC4
    } result_sel_t;

    typedef enum logic [1:0] {
        STEP_FORWARD,
        BRANCH,
        JUMP,
        JUMP_REG
    } pc_next_sel_t;

    typedef struct packed {
        logic         mem_w;
        logic         reg_w;
        result_sel_t  result_select;
        pc_next_sel_t pc_next_select;
        logic [3:0]   alu_ctrl;
        logic         alu_src;
    } bundle_decode_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } if_id_t;

    typedef struct packed {
        bundle_decode_t ctrl;
        logic [31:0]    pc;
        logic [31:0]    rd1;
        logic [31:0]    rd2;
        logic [31:0]    imm;
        logic [4:0]     rd;
    } id_ex_t;

    typedef struct packed {
        bundle_decode_t ctrl;
        logic [31:0]    alu_result;
        logic [31:0]    write_data;
        logic [4:0]     rd;
    } ex_mem_t;

    typedef struct packed {
        bundle_decode_t ctrl;
        logic [31:0]    alu_result;
        logic [31:0]    read_data;
        logic [4:0]     rd;
    } mem_wb_t;

    // A bubble never writes memory or registers and lets the PC step forward.
    localparam bundle_decode_t BUBBLE_CTRL = '{
        mem_w: 1'b0,
        reg_w: 1'b0,
        result_select: RESULT_ALU,
        pc_next_select: STEP_FORWARD,
        alu_ctrl: 4'd0,
        alu_src: 1'b0
    };

    localparam if_id_t  BUBBLE_IF_ID  = '0;
    localparam id_ex_t  BUBBLE_ID_EX  = {BUBBLE_CTRL, {($bits(id_ex_t) - $bits(bundle_decode_t)){1'b0}}};
    localparam ex_mem_t BUBBLE_EX_MEM = {BUBBLE_CTRL, {($bits(ex_mem_t) - $bits(bundle_decode_t)){1'b0}}};
    localparam mem_wb_t BUBBLE_MEM_WB = {BUBBLE_CTRL, {($bits(mem_wb_t) - $bits(bundle_decode_t)){1'b0}}};

endpackage

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: valid/ready pipeline boundary register with flush-to-bubble and optional 2-entry skid buffer
module pipe_stage_reg
    import pipe_stage_reg_pkg::*;
#(
    parameter int                DATA_W    = 128,
    parameter logic [DATA_W-1:0] RESET_VAL = '0,
    parameter bit                SKID      = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        occupancy
);

    logic [DATA_W-1:0] main_q;

    assign out_data = main_q;

    generate
        if (SKID) begin : g_skid
            stage_state_t      state, state_n;
            logic [DATA_W-1:0] skid_q;
            logic              it, ot, load_main, load_skid, pop_skid;

            // in_ready depends only on state, so a downstream stall never reaches upstream combinationally.
            assign in_ready  = state != TWO;
            assign out_valid = state != EMPTY;
            assign occupancy = state;
            assign it        = in_valid && in_ready;
            assign ot        = out_valid && out_ready;

            // Next state and payload routing; main always holds the older entry.
            always_comb begin
                state_n   = state;
                load_main = 1'b0;
                load_skid = 1'b0;
                pop_skid  = 1'b0;
                case (state)
                    EMPTY: begin
                        state_n   = it ? ONE : EMPTY;
                        load_main = it;
                    end
                    ONE: begin
                        state_n   = (it && !ot) ? TWO : (ot && !it) ? EMPTY : ONE;
                        load_main = it && ot;
                        load_skid = it && !ot;
                    end
                    TWO: begin
                        state_n  = ot ? ONE : TWO;
                        pop_skid = ot;
                    end
                    default: state_n = EMPTY;
                endcase
            end

            // State and payload registers; reset and flush both restore the bubble.
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    state  <= EMPTY;
                    main_q <= RESET_VAL;
                    skid_q <= RESET_VAL;
                end else begin
                    state <= state_n;
                    if (load_main) main_q <= in_data;
                    else if (pop_skid) main_q <= skid_q;
                    if (load_skid) skid_q <= in_data;
                end
            end

            a_no_load_when_full: assert property (@(posedge clk) disable iff (reset)
                (load_main || load_skid) |-> in_ready);
        end else begin : g_single
            logic valid_q, it, ot;

            assign in_ready  = !valid_q || out_ready;
            assign out_valid = valid_q;
            assign occupancy = {1'b0, valid_q};
            assign it        = in_valid && in_ready;
            assign ot        = valid_q && out_ready;

            // Single entry: load on accept, drain when consumed without a replacement.
            always_ff @(posedge clk) begin
                if (reset || flush) begin
                    valid_q <= 1'b0;
                    main_q  <= RESET_VAL;
                end else if (it) begin
                    valid_q <= 1'b1;
                    main_q  <= in_data;
                end else if (ot) begin
                    valid_q <= 1'b0;
                end
            end
        end
    endgenerate

    a_occ_max: assert property (@(posedge clk) disable iff (reset) occupancy != 2'd3);
    a_full_not_ready: assert property (@(posedge clk) disable iff (reset) (occupancy == 2'd2) |-> !in_ready);

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised pipeline boundary register for the 5-stage core. Replaces the per-stage hand-written IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Carries an opaque payload (packed datapath fields plus control bundle) with a valid/ready handshake, flush-to-bubble and optional 2-entry skid buffering.
- With skid buffering, backpressure from a downstream stall does not create a combinational ready path back through the pipe.

Parameters:
- DATA_W, 128, payload width in bits (packed struct width at instantiation).
- RESET_VAL, '0, payload value presented on reset and after flush (bubble encoding: MemW=0, RegW=0, ResultSelect=RESULT_ALU, PCNext_select=STEP_FORWARD).
- SKID, 1: 1 selects a 2-entry skid buffer with registered in_ready; 0 selects a single register with combinational in_ready.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream stage holds a valid payload.
- in_ready  out  1  this stage accepts the payload this cycle.
- in_data  in  DATA_W  upstream payload.
- flush  in  1  squash all held entries; from the hazard unit on a taken branch or jump.
- out_valid  out  1  out_data holds a valid payload.
- out_ready  in  1  downstream stage accepts the payload (not stalled).
- out_data  out  DATA_W  payload to the downstream stage; registered.
- occupancy  out  2  number of entries held (0..2; SKID=0 gives 0..1).

Behaviour:
- Transfers:
  - Input transfer (IT) = in_valid & in_ready.
  - Output transfer (OT) = out_valid & out_ready.
- Reset (priority 1):
  - out_valid=0, out_data=RESET_VAL, skid entry cleared, occupancy=0.
  - in_ready=1 from the first cycle after reset.
  - An IT in a reset cycle is discarded.
- Flush (priority 2, same effect as reset on state):
  - State goes to EMPTY, out_valid=0, out_data=RESET_VAL.
  - An IT in the same cycle is discarded.
  - An OT in the same cycle still counts downstream, because downstream samples before the edge.
- SKID=1, states EMPTY / ONE / TWO (occupancy 0/1/2):
  - in_ready is registered: 1 in EMPTY and ONE, 0 in TWO.
  - EMPTY: IT -> ONE, main<=in_data.
  - ONE, IT & OT -> ONE, main<=in_data.
  - ONE, IT & !OT -> TWO, skid<=in_data, main unchanged.
  - ONE, OT only -> EMPTY; out_data holds its last value, out_valid=0.
  - ONE, no transfer -> hold.
  - TWO: OT -> ONE, main<=skid. No IT is possible in TWO.
  - Order is preserved: the main entry is always older than the skid entry.
  - Latency in_data -> out_data is 1 cycle.
  - Full throughput: one IT and one OT per cycle in steady state.
- SKID=0:
  - Single entry, in_ready = !out_valid | out_ready (combinational).
  - IT loads main and sets out_valid=1.
  - OT without IT clears out_valid.
- Common rules, both modes:
  - While out_valid & !out_ready, out_data and out_valid stay stable.
  - The payload register loads only on an accepted transfer, never on idle cycles.
  - in_valid=0 with in_ready=1 is legal and inserts a bubble.
  - Simultaneous flush and stall: flush wins.
- Assertions:
  - occupancy never exceeds 2.
  - in_ready=0 whenever occupancy=2.
  - No IT when in_ready=0.

Decomposition:
- Shared package Pkg holds:
  - stage payload structs (if_id_t, id_ex_t, ex_mem_t, mem_wb_t) built from bundle_decode_t;
  - bubble constants (BUBBLE_EX_MEM etc.) used as RESET_VAL.
- No sub-module. The skid path is one generate branch inside pipe_stage_reg.
- Stage wrappers instantiate pipe_stage_reg with $bits(struct).

Test Plan:
- Reset, then DATA_W=32, SKID=1, in_valid=1, in_data=0x11, 0x22, 0x33 on consecutive cycles, out_ready=1 -> out_data 0x11, 0x22, 0x33 one cycle later each, out_valid=1 throughout, occupancy=1.
- Backpressure: out_ready=0 while 0xA1 then 0xA2 are sent -> occupancy 1, then 2; in_ready=0; out_data holds 0xA1. Then release out_ready=1 -> 0xA1, then 0xA2; in_ready returns to 1 after the first OT.
- Flush at occupancy=2 with in_valid=1, in_data=0xFF -> next cycle out_valid=0, out_data=RESET_VAL, occupancy=0, 0xFF never appears.
- Reset mid-stream at occupancy=1 -> out_valid=0, out_data=RESET_VAL; first post-reset input 0x5A appears with 1-cycle latency.
- SKID=0: out_ready toggles 1,0,1 with continuous input 0x01..0x04 -> in_ready follows out_ready | !out_valid; payloads arrive in order, none dropped or duplicated.
- Randomised valid/ready with scoreboard, 10k cycles, both SKID values -> output sequence equals input sequence; all assertions hold.
